// File: rtl/aes_pkg.sv
// Shared AES definitions: round counts, key-length codes, control/update
// encodings and the forward round transforms used by the encipher datapath.
package aes_pkg;

    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;

    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;

    typedef enum logic [2:0] {
        CTRL_IDLE = 3'd0,
        CTRL_INIT = 3'd1,
        CTRL_SBOX = 3'd2,
        CTRL_MAIN = 3'd3
    } ctrl_state_t;

    typedef enum logic [2:0] {
        UPD_NONE  = 3'd0,
        UPD_INIT  = 3'd1,
        UPD_SBOX  = 3'd2,
        UPD_MAIN  = 3'd3,
        UPD_FINAL = 3'd4
    } update_t;

    function automatic logic [7:0] gm2(input logic [7:0] op);
        return {op[6:0], 1'b0} ^ (8'h1b & {8{op[7]}});
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] op);
        return gm2(op) ^ op;
    endfunction

    // One column: MSB byte is row 0.
    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] data);
        return {mixw(data[127:96]), mixw(data[95:64]),
                mixw(data[63:32]),  mixw(data[31:0])};
    endfunction

    // Row r of column c takes row r of column (c + r) mod 4.
    function automatic logic [127:0] shiftrows(input logic [127:0] data);
        logic [31:0] w0, w1, w2, w3;
        w0 = data[127:96];
        w1 = data[95:64];
        w2 = data[63:32];
        w3 = data[31:0];
        return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Four parallel forward AES S-boxes on a 32-bit word, purely combinational.
module aes_sbox (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);

    // Entry b sits at bits [8*(255-b)+7 -: 8], i.e. entry 0 is the MSB byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'd7} -: 8];
    endfunction

    assign new_sboxw = {sbox_byte(sboxw[31:24]), sbox_byte(sboxw[23:16]),
                        sbox_byte(sboxw[15:8]),  sbox_byte(sboxw[7:0])};

endmodule

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher datapath. One S-box word per cycle, then a
// combined ShiftRows/MixColumns/AddRoundKey step per round.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// CTRL_IDLE | ready, waiting for next; result held in the block register
// CTRL_INIT | initial AddRoundKey with round 0 key
// CTRL_SBOX | SubBytes, one word per cycle selected by the sword counter
// CTRL_MAIN | ShiftRows/MixColumns/AddRoundKey, or final round without MixColumns
module aes_encipher_block (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    import aes_pkg::*;

    ctrl_state_t  state;
    update_t      upd;
    logic [31:0]  w0, w1, w2, w3;
    logic [1:0]   sword;
    logic [3:0]   round_ctr;
    logic [3:0]   num_rounds;
    logic         ready_reg;
    logic         keylen_reg;
    logic [127:0] old_block;
    logic [127:0] nb;
    logic [3:0]   we;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;

    assign old_block = {w0, w1, w2, w3};
    assign new_block = old_block;
    assign round     = round_ctr;
    assign ready     = ready_reg;

    assign num_rounds = (keylen_reg == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;

    aes_sbox u_sbox (
        .sboxw     (sbox_in),
        .new_sboxw (sbox_out)
    );

    // Select the word that goes through the shared S-box this cycle.
    always_comb begin
        sbox_in = w0;
        case (sword)
            2'd0:    sbox_in = w0;
            2'd1:    sbox_in = w1;
            2'd2:    sbox_in = w2;
            default: sbox_in = w3;
        endcase
    end

    // Decode the update type and produce next word values plus write enables.
    always_comb begin
        upd = UPD_NONE;
        nb  = '0;
        we  = 4'b0000;
        case (state)
            CTRL_INIT: upd = UPD_INIT;
            CTRL_SBOX: upd = UPD_SBOX;
            CTRL_MAIN: upd = (round_ctr < num_rounds) ? UPD_MAIN : UPD_FINAL;
            default:   upd = UPD_NONE;
        endcase

        case (upd)
            UPD_INIT: begin
                nb = block ^ round_key;
                we = 4'b1111;
            end
            UPD_SBOX: begin
                nb = {4{sbox_out}};
                we = 4'b0001 << sword;
            end
            UPD_MAIN: begin
                nb = mixcolumns(shiftrows(old_block)) ^ round_key;
                we = 4'b1111;
            end
            UPD_FINAL: begin
                nb = shiftrows(old_block) ^ round_key;
                we = 4'b1111;
            end
            default: begin
                nb = '0;
                we = 4'b0000;
            end
        endcase
    end

    // Block state words, each with its own write enable (we[i] -> wi).
    always_ff @(posedge clk) begin
        if (reset) begin
            w0 <= '0;
            w1 <= '0;
            w2 <= '0;
            w3 <= '0;
        end else begin
            if (we[0]) w0 <= nb[127:96];
            if (we[1]) w1 <= nb[95:64];
            if (we[2]) w2 <= nb[63:32];
            if (we[3]) w3 <= nb[31:0];
        end
    end

    // Control FSM with round/sword counters, ready and latched key length.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CTRL_IDLE;
            round_ctr  <= 4'd0;
            sword      <= 2'd0;
            ready_reg  <= 1'b1;
            keylen_reg <= AES_128_BIT_KEY;
        end else begin
            case (state)
                CTRL_IDLE: begin
                    if (next) begin
                        round_ctr  <= 4'd0;
                        keylen_reg <= keylen;
                        ready_reg  <= 1'b0;
                        state      <= CTRL_INIT;
                    end
                end
                CTRL_INIT: begin
                    round_ctr <= 4'd1;
                    sword     <= 2'd0;
                    state     <= CTRL_SBOX;
                end
                CTRL_SBOX: begin
                    sword <= sword + 2'd1;
                    if (sword == 2'd3) begin
                        state <= CTRL_MAIN;
                    end
                end
                CTRL_MAIN: begin
                    if (round_ctr < num_rounds) begin
                        round_ctr <= round_ctr + 4'd1;
                        sword     <= 2'd0;
                        state     <= CTRL_SBOX;
                    end else begin
                        ready_reg <= 1'b1;
                        state     <= CTRL_IDLE;
                    end
                end
                default: begin
                    state <= CTRL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Self-checking bench for aes_encipher_block. The reference model builds the
// S-box from GF(2^8) inversion, expands keys per FIPS-197 and runs the cipher
// on a byte array; it also acts as the key memory indexed by the DUT's round.
module tb_aes_encipher_block;

    logic         clk;
    logic         reset;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [256];
    logic [127:0] rk [16];
    logic [3:0]   rtrace [$];

    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_encipher_block dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign round_key = rk[round];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] l;
        logic [7:0] r;
        l = x << n;
        r = x >> (8 - n);
        return l | r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input logic kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Byte k of the state is row k%4, column k/4.
    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic kl);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k;
        logic [127:0] res;
        int nr;
        nr = kl ? 14 : 10;
        k = rk[0];
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4*c + rr] = s[4*((c + rr) % 4) + rr];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    if (r < nr)
                        s[4*c + rr] = gmul(8'h02, t[4*c + rr]) ^ gmul(8'h03, t[4*c + (rr+1)%4])
                                    ^ t[4*c + (rr+2)%4] ^ t[4*c + (rr+3)%4];
                    else
                        s[4*c + rr] = t[4*c + rr];
            k = rk[r];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Launch one operation; edge n counts from the accepting edge E0.
    // lat = edge index at which ready is seen high, -1 on timeout or abort.
    task automatic do_op(input logic [255:0] key, input logic kl, input logic [127:0] pt,
                         input int pulse_a, input int pulse_b, input int flip_at, input int reset_at,
                         output int lat, output logic [127:0] ct, output logic [127:0] held);
        expand_key(key, kl);
        @(negedge clk);
        block  = pt;
        keylen = kl;
        next   = 1'b1;
        @(posedge clk);
        #1;
        next = 1'b0;
        held = new_block;
        rtrace.delete();
        rtrace.push_back(round);
        lat = -1;
        ct  = '0;
        for (int n = 1; n <= 120; n++) begin
            if (n == pulse_a || n == pulse_b) next = 1'b1;
            if (n == flip_at) keylen = ~kl;
            if (n == reset_at) reset = 1'b1;
            @(posedge clk);
            #1;
            next  = 1'b0;
            reset = 1'b0;
            if (n == 1) block = rand128();
            if (n == reset_at) return;
            if (ready) begin
                lat = n;
                break;
            end
            rtrace.push_back(round);
        end
        ct = new_block;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", ready);
        end
        checks++;
        if (round !== 4'd0) begin
            errors++;
            $display("FAIL reset_round: got %0d expected 0", round);
        end
        checks++;
        if (new_block !== 128'h0) begin
            errors++;
            $display("FAIL reset_block: got %h expected 0", new_block);
        end
    endtask

    task automatic test_fips128();
        int lat;
        logic [127:0] ct;
        logic [127:0] held;
        do_op(KEY_C1, 1'b0, PT_C, 0, 0, 0, 0, lat, ct, held);
        checks++;
        if (ct !== CT_C1) begin
            errors++;
            $display("FAIL c1_ct: got %h expected %h", ct, CT_C1);
        end
        checks++;
        if (lat != 51) begin
            errors++;
            $display("FAIL c1_latency: got %0d expected 51", lat);
        end
    endtask

    task automatic test_fips256();
        int lat;
        logic [127:0] ct;
        logic [127:0] held;
        do_op(KEY_C3, 1'b1, PT_C, 0, 0, 0, 0, lat, ct, held);
        checks++;
        if (ct !== CT_C3) begin
            errors++;
            $display("FAIL c3_ct: got %h expected %h", ct, CT_C3);
        end
        checks++;
        if (lat != 71) begin
            errors++;
            $display("FAIL c3_latency: got %0d expected 71", lat);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        logic [127:0] ct;
        logic [127:0] held;
        do_op(KEY_C1, 1'b0, PT_C, 0, 0, 0, 20, lat, ct, held);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: got %b expected 1", ready);
        end
        checks++;
        if (round !== 4'd0) begin
            errors++;
            $display("FAIL midreset_round: got %0d expected 0", round);
        end
        checks++;
        if (new_block !== 128'h0) begin
            errors++;
            $display("FAIL midreset_block: got %h expected 0", new_block);
        end
        do_op(KEY_C1, 1'b0, PT_C, 0, 0, 0, 0, lat, ct, held);
        checks++;
        if (ct !== CT_C1 || lat != 51) begin
            errors++;
            $display("FAIL midreset_rerun: got %h/%0d expected %h/51", ct, lat, CT_C1);
        end
    endtask

    task automatic test_ignored_next();
        int lat;
        logic [127:0] ct;
        logic [127:0] held;
        do_op(KEY_C1, 1'b0, PT_C, 5, 30, 0, 0, lat, ct, held);
        checks++;
        if (ct !== CT_C1) begin
            errors++;
            $display("FAIL busy_next_ct: got %h expected %h", ct, CT_C1);
        end
        checks++;
        if (lat != 51) begin
            errors++;
            $display("FAIL busy_next_latency: got %0d expected 51", lat);
        end
    endtask

    task automatic test_keylen_latch();
        int lat;
        logic [127:0] ct;
        logic [127:0] held;
        logic [3:0] exp_r;
        do_op(KEY_C1, 1'b0, PT_C, 0, 0, 3, 0, lat, ct, held);
        keylen = 1'b0;
        checks++;
        if (ct !== CT_C1 || lat != 51) begin
            errors++;
            $display("FAIL keylen_latch: got %h/%0d expected %h/51", ct, lat, CT_C1);
        end
        checks++;
        if (rtrace.size() != 51) begin
            errors++;
            $display("FAIL round_trace_len: got %0d expected 51", rtrace.size());
        end
        for (int k = 0; k < rtrace.size() && k < 51; k++) begin
            exp_r = (k == 0) ? 4'd0 : 4'((k - 1) / 5 + 1);
            checks++;
            if (rtrace[k] !== exp_r) begin
                errors++;
                $display("FAIL round_trace[%0d]: got %0d expected %0d", k, rtrace[k], exp_r);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] ct;
        logic [127:0] held;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] exp_ct;
        logic kl;
        for (int i = 0; i < 6; i++) begin
            key = {rand128(), rand128()};
            pt  = rand128();
            kl  = 1'($urandom_range(0, 1));
            expand_key(key, kl);
            exp_ct = model_encrypt(pt, kl);
            do_op(key, kl, pt, 0, 0, 0, 0, lat, ct, held);
            checks++;
            if (ct !== exp_ct) begin
                errors++;
                $display("FAIL random_ct[%0d] kl=%0d: got %h expected %h", i, kl, ct, exp_ct);
            end
            checks++;
            if (lat != (kl ? 71 : 51)) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, kl ? 71 : 51);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [127:0] ct1;
        logic [127:0] ct2;
        logic [127:0] held;
        logic [127:0] exp_ct;
        logic [127:0] pt2;
        pt2 = 128'hffeeddccbbaa99887766554433221100;
        // next is also high in the cycle ready rises; that pulse must be dropped.
        do_op(KEY_C1, 1'b0, PT_C, 51, 0, 0, 0, lat, ct1, held);
        checks++;
        if (ct1 !== CT_C1 || lat != 51) begin
            errors++;
            $display("FAIL b2b_first: got %h/%0d expected %h/51", ct1, lat, CT_C1);
        end
        expand_key(KEY_C1, 1'b0);
        exp_ct = model_encrypt(pt2, 1'b0);
        do_op(KEY_C1, 1'b0, pt2, 0, 0, 0, 0, lat, ct2, held);
        checks++;
        if (held !== ct1) begin
            errors++;
            $display("FAIL b2b_held: got %h expected %h", held, ct1);
        end
        checks++;
        if (ct2 !== exp_ct) begin
            errors++;
            $display("FAIL b2b_second_ct: got %h expected %h", ct2, exp_ct);
        end
        checks++;
        if (lat != 51) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d expected 51", lat);
        end
    endtask

    initial begin
        reset  = 1'b1;
        next   = 1'b0;
        keylen = 1'b0;
        block  = '0;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        build_sbox();
        test_reset();
        test_fips128();
        test_fips256();
        test_mid_reset();
        test_ignored_next();
        test_keylen_latch();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
